instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/isa_pkg.sv | 53 +++++
 rtl/op_legal_chk.sv | 11 +
 rtl/instr_encoder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder and the control decoder:
// the encoded word width, field widths and the 28 legal opcodes.
package isa_pkg;

  localparam int INSTR_W   = 9;
  localparam int OP_W      = 5;
  localparam int OPERAND_W = 4;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_MOVI = 5'b00001;
  localparam logic [4:0] OP_LDI  = 5'b00010;
  localparam logic [4:0] OP_LD   = 5'b00011;
  localparam logic [4:0] OP_ST   = 5'b00100;
  localparam logic [4:0] OP_PUSH = 5'b00101;
  localparam logic [4:0] OP_POP  = 5'b00110;
  localparam logic [4:0] OP_MOV  = 5'b00111;
  localparam logic [4:0] OP_ADD  = 5'b01000;
  localparam logic [4:0] OP_SUB  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_XOR  = 5'b01100;
  localparam logic [4:0] OP_NOT  = 5'b01101;
  localparam logic [4:0] OP_SHL  = 5'b01110;
  localparam logic [4:0] OP_SHR  = 5'b01111;
  localparam logic [4:0] OP_CMP  = 5'b10000;
  localparam logic [4:0] OP_TST  = 5'b10001;
  // 10010..10101 are reserved and never encoded
  localparam logic [4:0] OP_B    = 5'b10110;
  localparam logic [4:0] OP_BZ   = 5'b10111;
  localparam logic [4:0] OP_BNZ  = 5'b11000;
  localparam logic [4:0] OP_BC   = 5'b11001;
  localparam logic [4:0] OP_CALL = 5'b11010;
  localparam logic [4:0] OP_RET  = 5'b11011;
  localparam logic [4:0] OP_IN   = 5'b11100;
  localparam logic [4:0] OP_OUT  = 5'b11101;
  localparam logic [4:0] OP_EI   = 5'b11110;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NOP, 4'b0000};

  function automatic logic op_is_legal(input logic [4:0] op);
    logic legal;
    case (op)
      OP_NOP, OP_MOVI, OP_LDI, OP_LD, OP_ST, OP_PUSH, OP_POP, OP_MOV,
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
      OP_CMP, OP_TST, OP_B, OP_BZ, OP_BNZ, OP_BC, OP_CALL, OP_RET,
      OP_IN, OP_OUT, OP_EI, OP_HALT: legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/op_legal_chk.sv
// Combinational opcode legality check against the shared ISA opcode set.
module op_legal_chk
  import isa_pkg::*;
(
  input  logic [4:0] op,
  output logic       legal
);

  assign legal = op_is_legal(op);

endmodule

// File: rtl/instr_encoder.sv
// Packs {op, operand} requests into 9-bit words written to instruction memory.
// Optional feature: define ENC_NOP_PAD_EN to pad the program with NOPs to a 4-word boundary.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4:0]         req_op,
  input  logic [3:0]         req_operand,
  input  logic               req_last,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               done,
  output logic               full,
  output logic               err_illegal
);

`ifdef ENC_NOP_PAD_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WRITE  = 3'd2,
    DONE   = 3'd3,
    PAD    = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WRITE  = 3'd2,
    DONE   = 3'd3
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t               state_r;
  logic [ADDR_W-1:0]    addr_r;
  logic                 we_r;
  logic [INSTR_W-1:0]   wdata_r;
  logic                 done_r;
  logic                 full_r;
  logic                 err_r;
  logic                 last_r;
  logic                 legal_r;
  logic                 op_legal_s;
  logic                 accept_s;
  logic [ADDR_W-1:0]    inc_addr_s;
`ifdef ENC_NOP_PAD_EN
  logic [ADDR_W-1:0]    wr_next_addr_s;
`endif

  op_legal_chk u_op_legal_chk (
    .op    (req_op),
    .legal (op_legal_s)
  );

  // A start pulse always wins, so it masks ready in the cycle it arrives
  assign req_ready  = (state_r == ACCEPT) && !start;
  assign accept_s   = req_valid && req_ready;
  assign inc_addr_s = addr_r + ADDR_ONE;
`ifdef ENC_NOP_PAD_EN
  assign wr_next_addr_s = legal_r ? inc_addr_s : addr_r;
`endif

  assign im_we       = we_r;
  assign im_addr     = addr_r;
  assign im_wdata    = wdata_r;
  assign done        = done_r;
  assign full        = full_r;
  assign err_illegal = err_r;

  // Load sequencer: accept a request, write it the next cycle, optionally pad, then hold done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      addr_r  <= '0;
      we_r    <= 1'b0;
      wdata_r <= '0;
      done_r  <= 1'b0;
      full_r  <= 1'b0;
      err_r   <= 1'b0;
      last_r  <= 1'b0;
      legal_r <= 1'b0;
    end else if (start) begin
      state_r <= ACCEPT;
      addr_r  <= '0;
      we_r    <= 1'b0;
      wdata_r <= '0;
      done_r  <= 1'b0;
      full_r  <= 1'b0;
      err_r   <= 1'b0;
      last_r  <= 1'b0;
      legal_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          we_r <= 1'b0;
        end
        ACCEPT: begin
          if (accept_s) begin
            last_r  <= req_last;
            legal_r <= op_legal_s;
            state_r <= WRITE;
            if (op_legal_s) begin
              we_r    <= 1'b1;
              wdata_r <= {req_op, req_operand};
            end else begin
              we_r  <= 1'b0;
              err_r <= 1'b1;
            end
          end else begin
            we_r <= 1'b0;
          end
        end
        WRITE: begin
          we_r <= 1'b0;
          // The top address is written once and never wrapped past
          if (legal_r && (addr_r == LAST_ADDR)) begin
            full_r  <= 1'b1;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            if (legal_r) begin
              addr_r <= inc_addr_s;
            end else begin
              addr_r <= addr_r;
            end
            if (last_r) begin
`ifdef ENC_NOP_PAD_EN
              if (wr_next_addr_s[1:0] != 2'b00) begin
                state_r <= PAD;
                we_r    <= 1'b1;
                wdata_r <= NOP_WORD;
              end else begin
                state_r <= DONE;
                done_r  <= 1'b1;
              end
`else
              state_r <= DONE;
              done_r  <= 1'b1;
`endif
            end else begin
              state_r <= ACCEPT;
            end
          end
        end
`ifdef ENC_NOP_PAD_EN
        PAD: begin
          if (addr_r == LAST_ADDR) begin
            we_r    <= 1'b0;
            full_r  <= 1'b1;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            addr_r <= inc_addr_s;
            if (inc_addr_s[1:0] == 2'b00) begin
              we_r    <= 1'b0;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              we_r <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          we_r <= 1'b0;
        end
        default: begin
          we_r    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
